// File: rtl/array_drain_collector_pkg.sv
// Shared sizing, FSM encoding and column-slice helper for the systolic drain collector.
package drain_pkg;
    localparam int N     = 16;
    localparam int ACC_W = 20;
    localparam int CNT_W = 5;
    localparam int IDX_W = $clog2(N);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_EMIT    = 1'b1;

    function automatic logic [ACC_W-1:0] col_slice(input logic [N*ACC_W-1:0] data, input int c);
        return data[c*ACC_W +: ACC_W];
    endfunction
endpackage

// File: rtl/array_drain_collector_if.sv
// Drain input stream and tile-row output stream of the drain collector.
interface array_drain_collector_if;
    import drain_pkg::*;

    logic [N*ACC_W-1:0] col_in;
    logic [N-1:0]       col_valid;
    logic               busy;
    logic [N*ACC_W-1:0] out_data;
    logic [CNT_W-1:0]   out_row;
    logic               out_valid;
    logic               out_last;
    logic               out_ready;
    logic               err_overflow;

    modport master (
        output col_in, col_valid, out_ready,
        input  busy, out_data, out_row, out_valid, out_last, err_overflow
    );

    modport slave (
        input  col_in, col_valid, out_ready,
        output busy, out_data, out_row, out_valid, out_last, err_overflow
    );
endinterface

// File: rtl/array_drain_collector_tracker.sv
// Per-column beat counter: turns the k-th drain beat into write row N-1-k and flags extra beats.
module drain_column_tracker
    import drain_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             sync_reset,
    input  logic             clear_i,
    input  logic             valid_i,
    input  logic             collect_i,
    output logic             wr_en_o,
    output logic             overflow_o,
    output logic             done_next_o,
    output logic             active_o,
    output logic [CNT_W-1:0] wr_row_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done;

    assign done        = (cnt_q == CNT_W'(N));
    assign active_o    = (cnt_q != '0);
    assign wr_en_o     = !sync_reset && collect_i && valid_i && !done;
    assign overflow_o  = !sync_reset && valid_i && (!collect_i || done);
    assign wr_row_o    = CNT_W'(N-1) - cnt_q;
    assign done_next_o = done || (wr_en_o && (cnt_q == CNT_W'(N-1)));

    always_comb begin
        cnt_d = cnt_q;
        if (sync_reset || clear_i) begin
            cnt_d = '0;
        end else if (wr_en_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/array_drain_collector.sv
// Collects skewed per-column drain streams into an N x N tile and streams it out row by row.
module array_drain_collector
    import drain_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sync_reset,
    array_drain_collector_if.slave  bus
);
    logic [0:0]         state_q, state_d;
    logic [CNT_W-1:0]   row_q, row_d;
    logic               out_valid_q, out_valid_d;
    logic [N*ACC_W-1:0] out_data_q, out_data_d;
    logic               err_q, err_d;
    logic               clear_cnt;
    logic               collect;
    logic               handshake;

    logic [ACC_W-1:0]   mem [N][N];
    logic [N-1:0]       wr_en, ovf, done_next, active;
    logic [CNT_W-1:0]   wr_row [N];

    assign collect   = (state_q == ST_COLLECT);
    assign handshake = out_valid_q && bus.out_ready;

    for (genvar c = 0; c < N; c++) begin : g_col
        drain_column_tracker u_trk (
            .clk         (clk),
            .rst         (rst),
            .sync_reset  (sync_reset),
            .clear_i     (clear_cnt),
            .valid_i     (bus.col_valid[c]),
            .collect_i   (collect),
            .wr_en_o     (wr_en[c]),
            .overflow_o  (ovf[c]),
            .done_next_o (done_next[c]),
            .active_o    (active[c]),
            .wr_row_o    (wr_row[c])
        );
    end

    // Row 0 is written by each column's final beat, so the first emitted row bypasses mem.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        err_d       = err_q | (|ovf);
        clear_cnt   = 1'b0;
        if (sync_reset) begin
            state_d     = ST_COLLECT;
            row_d       = '0;
            out_valid_d = 1'b0;
            err_d       = 1'b0;
        end else if (state_q == ST_COLLECT) begin
            if (&done_next) begin
                state_d     = ST_EMIT;
                row_d       = '0;
                out_valid_d = 1'b1;
                for (int c = 0; c < N; c++) begin
                    out_data_d[c*ACC_W +: ACC_W] = (wr_en[c] && (wr_row[c] == '0))
                                                 ? col_slice(bus.col_in, c) : mem[0][c];
                end
            end
        end else if (handshake) begin
            if (row_q == CNT_W'(N-1)) begin
                state_d     = ST_COLLECT;
                row_d       = '0;
                out_valid_d = 1'b0;
                clear_cnt   = 1'b1;
            end else begin
                row_d = row_q + 1'b1;
                for (int c = 0; c < N; c++) begin
                    out_data_d[c*ACC_W +: ACC_W] = mem[row_d[IDX_W-1:0]][c];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_COLLECT;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < N; c++) begin
            if (wr_en[c]) begin
                mem[wr_row[c][IDX_W-1:0]][c] <= col_slice(bus.col_in, c);
            end
        end
    end

    assign bus.busy         = (state_q == ST_EMIT) || (|active);
    assign bus.out_data     = out_data_q;
    assign bus.out_row      = row_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_last     = out_valid_q && (row_q == CNT_W'(N-1));
    assign bus.err_overflow = err_q;
endmodule

// File: tb/tb_array_drain_collector.sv
// Directed bench for array_drain_collector: aligned/skewed drains, backpressure, overflow and clears.
module tb_array_drain_collector;
    import drain_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic syncReset;
    int   passCount = 0;
    int   checkCount = 0;
    bit   readyPat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    array_drain_collector_if bus ();

    array_drain_collector dut (
        .clk        (clk),
        .rst        (rst),
        .sync_reset (syncReset),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic checkData(input string tag, input logic [N*ACC_W-1:0] obs, input logic [N*ACC_W-1:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [N*ACC_W-1:0] expRowData(input int base, input int r);
        logic [N*ACC_W-1:0] v;
        for (int c = 0; c < N; c++) begin
            v[c*ACC_W +: ACC_W] = ACC_W'(base + 100*c + (N-1-r));
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Column c beat k carries base+100*c+k; column c starts skew*c cycles after column 0.
    task automatic applyStimulus(input int base, input int skew, input logic [N-1:0] mask,
                                 input int nBeats, input bit expectEmit);
        int span;
        int k;
        span = nBeats + skew*(N-1);
        for (int t = 0; t < span; t++) begin
            for (int c = 0; c < N; c++) begin
                k = t - skew*c;
                if (mask[c] && k >= 0 && k < nBeats) begin
                    bus.col_valid[c] = 1'b1;
                    bus.col_in[c*ACC_W +: ACC_W] = ACC_W'(base + 100*c + k);
                end else begin
                    bus.col_valid[c] = 1'b0;
                    bus.col_in[c*ACC_W +: ACC_W] = '0;
                end
            end
            if (expectEmit && t == span-1) checkOutput("validBeforeLastBeat", bus.out_valid, 0);
            tick();
        end
        bus.col_valid = '0;
        bus.col_in    = '0;
    endtask

    task automatic receiveTile(input string tag, input int base, input bit backpressure);
        int expRow;
        int cyc;
        expRow = 0;
        cyc = 0;
        while (expRow < N && cyc < 200) begin
            bus.out_ready = backpressure ? readyPat[cyc % 4] : 1'b1;
            checkOutput({tag, "_valid"}, bus.out_valid, 1);
            if (bus.out_valid) begin
                checkOutput({tag, "_row"}, bus.out_row, expRow);
                checkOutput({tag, "_last"}, bus.out_last, (expRow == N-1));
                checkOutput({tag, "_busy"}, bus.busy, 1);
                checkData({tag, "_data"}, bus.out_data, expRowData(base, expRow));
                if (bus.out_ready) expRow++;
            end
            tick();
            cyc++;
        end
        bus.out_ready = 1'b0;
        checkOutput({tag, "_transfers"}, expRow, N);
        checkOutput({tag, "_validAfterLast"}, bus.out_valid, 0);
        checkOutput({tag, "_busyAfterLast"}, bus.busy, 0);
    endtask

    initial begin
        rst           = 1'b1;
        syncReset     = 1'b0;
        bus.col_in    = '0;
        bus.col_valid = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        checkOutput("rstValid", bus.out_valid, 0);
        checkOutput("rstBusy", bus.busy, 0);
        checkOutput("rstErr", bus.err_overflow, 0);
        checkOutput("rstRow", bus.out_row, 0);
        checkOutput("rstLast", bus.out_last, 0);
        checkData("rstData", bus.out_data, '0);

        $display("[TB] aligned drain");
        applyStimulus(0, 0, '1, N, 1'b1);
        checkOutput("alignedLatency", bus.out_valid, 1);
        receiveTile("aligned", 0, 1'b0);

        $display("[TB] skewed drain");
        applyStimulus(0, 1, '1, N, 1'b1);
        checkOutput("skewLatency", bus.out_valid, 1);
        receiveTile("skewed", 0, 1'b0);

        $display("[TB] overflow in COLLECT");
        applyStimulus(0, 0, 16'h0008, N, 1'b0);
        checkOutput("col3DoneBusy", bus.busy, 1);
        checkOutput("col3DoneErr", bus.err_overflow, 0);
        bus.col_valid = 16'h0008;
        bus.col_in[3*ACC_W +: ACC_W] = 20'hFFFFF;
        tick();
        bus.col_valid = '0;
        bus.col_in    = '0;
        checkOutput("ovfCollectErr", bus.err_overflow, 1);
        checkOutput("ovfCollectValid", bus.out_valid, 0);
        applyStimulus(0, 0, 16'hFFF7, N, 1'b1);
        checkOutput("ovfTileValid", bus.out_valid, 1);
        receiveTile("ovfCollect", 0, 1'b0);
        checkOutput("ovfErrSticky", bus.err_overflow, 1);

        $display("[TB] overflow in EMIT");
        applyStimulus(1000, 0, '1, N, 1'b1);
        bus.col_valid = '1;
        bus.col_in    = '1;
        tick();
        tick();
        bus.col_valid = '0;
        bus.col_in    = '0;
        checkOutput("ovfEmitErr", bus.err_overflow, 1);
        checkOutput("ovfEmitRow", bus.out_row, 0);
        receiveTile("ovfEmit", 1000, 1'b0);

        $display("[TB] sync_reset during EMIT");
        applyStimulus(1500, 0, '1, N, 1'b1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus.out_ready = 1'b0;
        checkOutput("preSyncRow", bus.out_row, 5);
        checkOutput("preSyncErr", bus.err_overflow, 1);
        syncReset = 1'b1;
        tick();
        syncReset = 1'b0;
        checkOutput("syncValid", bus.out_valid, 0);
        checkOutput("syncBusy", bus.busy, 0);
        checkOutput("syncErr", bus.err_overflow, 0);

        $display("[TB] rst mid-drain then backpressured tile");
        applyStimulus(500, 0, '1, 8, 1'b0);
        checkOutput("partialBusy", bus.busy, 1);
        rst = 1'b1;
        #2;
        checkOutput("asyncRstBusy", bus.busy, 0);
        checkOutput("asyncRstValid", bus.out_valid, 0);
        rst = 1'b0;
        applyStimulus(2000, 0, '1, N, 1'b1);
        checkOutput("postRstLatency", bus.out_valid, 1);
        receiveTile("backpressure", 2000, 1'b1);

        $display("[TB] back-to-back tile");
        applyStimulus(3000, 0, '1, N, 1'b1);
        checkOutput("b2bLatency", bus.out_valid, 1);
        receiveTile("backToBack", 3000, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/array_drain_collector.md
Name: array_drain_collector

Overview:
- Receiver at the bottom of the systolic array. Captures the partial-sum drain stream that each last-row PE emits on its column output while its drain-valid is high.
- Reassembles the streams into an N x N result tile and emits the tile one row per beat over a valid/ready stream to the activation/accumulator stage.
- Column streams may be skewed by any number of cycles relative to one another.

Parameters:
- N, 16, array dimension: rows per column drain and number of columns.
- ACC_W, 20, width of one partial sum, matching the PE column-result width.
- CNT_W, 5, counter width; must satisfy 2^CNT_W > N.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- sync_reset  in  1  synchronous clear of control state; tile storage is not cleared.
- col_in  in  N*ACC_W  drain data; column c occupies bits [c*ACC_W +: ACC_W].
- col_valid  in  N  per-column drain valid from each last-row PE.
- busy  out  1  high while not in COLLECT or while any column is partially received; the GEMM controller must not start a new drain-producing pass while busy=1.
- out_data  out  N*ACC_W  one tile row; column c occupies bits [c*ACC_W +: ACC_W].
- out_row  out  CNT_W  row index of out_data.
- out_valid  out  1  out_data is valid.
- out_last  out  1  high with out_valid on row N-1.
- out_ready  in  1  downstream accept.
- err_overflow  out  1  sticky; cleared only by rst or sync_reset.

Behaviour:
- Reset values: all outputs 0, state COLLECT, all column counters 0.
- Storage: mem[N][N] of ACC_W-bit entries. Storage is not reset.
- States:
  - COLLECT: capture drain beats until every column has received N beats.
  - EMIT: stream the tile out row by row.
- Drain order: the beats of one column arrive with the bottom row first. For the k-th valid beat (k = 0..N-1) on column c, write mem[N-1-k][c] = col_in slice c, then increment cnt[c].
- Column completion:
  - When cnt[c] == N, the column is done.
  - Any further col_valid[c] in COLLECT is dropped and sets err_overflow; cnt[c] does not change.
- Entering EMIT: on the cycle after the final beat completes the last column, state becomes EMIT and out_valid rises with out_row = 0. Latency from last capture to first out_valid is 1 clock.
- EMIT:
  - out_data = mem[out_row], registered.
  - A beat transfers only when out_valid and out_ready are both high; out_row then increments.
  - out_data, out_row and out_last hold stable while out_valid=1 and out_ready=0.
  - The handshake on row N-1 (out_last=1) clears out_valid, zeroes all counters and returns to COLLECT in the same edge.
  - out_valid never drops without a handshake.
- col_valid in EMIT: any col_valid bit high drops the beat and sets err_overflow.
- Simultaneous events: in COLLECT, beats on different columns in the same cycle are all captured.
- sync_reset: priority over every other action in the cycle. Sets state COLLECT, counters 0, out_valid 0, err_overflow 0; mem is untouched.
- rst mid-operation: immediate return to reset values; a partially collected or partially emitted tile is discarded.
- Width rules: data is passed through unmodified at ACC_W bits. No saturation or sign handling in this block.

Decomposition:
- Shared package drain_pkg:
  - localparams N, ACC_W, CNT_W.
  - State encoding ST_COLLECT = 1'b0, ST_EMIT = 1'b1.
  - Slice helper for the column index.
- Sub-module drain_column_tracker, instantiated N times:
  - Owns one cnt[c], its done flag and its overflow pulse.
  - Produces the write-row index N-1-cnt.
- Top level owns mem, the FSM, the emit row counter and the sticky error.

Test Plan:
- Aligned drain: all 16 columns valid for 16 consecutive cycles, column c beat k = 100*c + k. Required: out_valid rises 1 cycle after the last beat; row r column c = 100*c + (15-r); rows 0..15 in order; out_last on row 15.
- Skewed drain: column c starts c cycles after column 0, same data as above. Required: identical tile; busy stays 1 until the final row handshake; first out_valid 1 cycle after column 15 beat 15.
- Backpressure: out_ready toggles 1,0,0,1 repeating. Required: out_data and out_row stable while stalled; exactly 16 transfers; no row skipped or duplicated.
- Overflow: column 3 gets a 17th beat of 0xFFFFF during COLLECT. Required: err_overflow=1 and stays 1; mem row 0 column 3 keeps its 16th value. A second test drives col_valid during EMIT and requires the same error with the tile unchanged.
- Mid-operation clears: assert rst after 8 beats, then run a full aligned drain. Required: a correct tile, not the earlier partial data. Then assert sync_reset during EMIT at row 5. Required: out_valid=0 next cycle, state COLLECT, err_overflow=0.
- Back-to-back tiles: start a second aligned drain right after the out_last handshake. Required: the second tile is captured completely and emitted with the new values.
